// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the vector data memory between pipeline and FIR loader
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   p0_req/we/addr/wdata  pipeline Memory-stage request; payload held until p0_done
//   p0_rdata, p0_done   registered read data, one-cycle completion pulse
//   stall_m             p0_req & ~p0_done, to the hazard unit
//   p1_*                FIR sample/coefficient loader port, same protocol as port 0
//   mem_en/we/addr/wdata  one-cycle access strobe with registered command to the memory macro
//   mem_rdata           read data, valid exactly MEM_LAT cycles after the mem_en cycle
module dmem_arbiter #(
   parameter int DATA_W  = 256,
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_done,
   output logic              stall_m,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       gnt;
   logic       last_grant;
   logic       any_req;
   logic       winner;
   logic [3:0] cnt;

   assign any_req = p0_req | p1_req;
   // On a tie the port that was not served last wins; otherwise the lone requester wins.
   assign winner  = (p0_req & p1_req) ? ~last_grant : p1_req;
   assign stall_m = p0_req & ~p0_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      p0_done   = 1'b0;
      p1_done   = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mem_en    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == 4'd1) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            p0_done   = ~gnt;
            p1_done   = gnt;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= 4'd0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         p0_rdata   <= '0;
         p1_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt        <= winner;
                  last_grant <= winner;
                  mem_we     <= winner ? p1_we    : p0_we;
                  mem_addr   <= winner ? p1_addr  : p0_addr;
                  mem_wdata  <= winner ? p1_wdata : p0_wdata;
               end
            end
            ISSUE: begin
               cnt <= 4'(MEM_LAT);
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               // cnt==1 is the cycle in which the macro presents the read data.
               if (cnt == 4'd1 && !mem_we) begin
                  if (gnt) begin
                     p1_rdata <= mem_rdata;
                  end else begin
                     p0_rdata <= mem_rdata;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;

   localparam int DW = 256;
   localparam int AW = 32;
   localparam int NI = 3;
   localparam int L0 = 2;
   localparam logic [DW-1:0] BAD = {8{32'hDEAD_BEEF}};

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NI-1:0]         p0_req, p0_we, p0_done, stall_m, p1_req, p1_we, p1_done, mem_en, mem_we;
   logic [NI-1:0][AW-1:0] p0_addr, p1_addr, mem_addr;
   logic [NI-1:0][DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;

   function automatic logic [DW-1:0] init_word(input int a);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(a);
      return {8{w}};
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = (g == 0) ? L0 : ((g == 1) ? 1 : 15);
      logic [DW-1:0] store [16];
      bit            written [16];
      logic [DW-1:0] due_data;
      int            due;

      dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .p0_req    (p0_req[g]),
         .p0_we     (p0_we[g]),
         .p0_addr   (p0_addr[g]),
         .p0_wdata  (p0_wdata[g]),
         .p0_rdata  (p0_rdata[g]),
         .p0_done   (p0_done[g]),
         .stall_m   (stall_m[g]),
         .p1_req    (p1_req[g]),
         .p1_we     (p1_we[g]),
         .p1_addr   (p1_addr[g]),
         .p1_wdata  (p1_wdata[g]),
         .p1_rdata  (p1_rdata[g]),
         .p1_done   (p1_done[g]),
         .mem_en    (mem_en[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g])
      );

      // Memory macro: writes land on the strobe, read data is shown only in its single valid cycle.
      always @(posedge clk) begin
         if (mem_en[g]) begin
            if (mem_we[g]) begin
               store[mem_addr[g][3:0]]   <= mem_wdata[g];
               written[mem_addr[g][3:0]] <= 1'b1;
            end else begin
               due_data <= written[mem_addr[g][3:0]] ? store[mem_addr[g][3:0]]
                                                      : init_word(int'(mem_addr[g][3:0]));
               due      <= cyc + LAT;
            end
         end
      end
      assign mem_rdata[g] = (cyc == due) ? due_data : BAD;
   end

   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] model_mem [16];
   logic [DW-1:0] model_rd [2];
   int            model_last;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic rand_payload();
      logic [31:0] r;
      for (int p = 0; p < 2; p++) begin
         r = $urandom;
         if (p == 0) begin
            p0_we[0]   = r[8];
            p0_addr[0] = {r[31:4], 2'b00, r[1:0]};
            for (int i = 0; i < 8; i++) p0_wdata[0][i*32 +: 32] = $urandom;
         end else begin
            p1_we[0]   = r[9];
            p1_addr[0] = {r[31:4], 2'b00, r[1:0]};
            for (int i = 0; i < 8; i++) p1_wdata[0][i*32 +: 32] = $urandom;
         end
      end
   endtask

   // One transaction group on instance 0, entered at posedge+1 with the arbiter idle.
   // p1 rises d1 cycles after p0 (d1 > 0 only when both ports request).
   task automatic step(input bit r0, input bit r1, input int d1);
      int            first;
      int            last;
      int            t_iss [2];
      int            t_done [2];
      bit            w [2];
      logic [AW-1:0] af [2];
      logic [DW-1:0] d [2];
      w[0] = p0_we[0];  af[0] = p0_addr[0];  d[0] = p0_wdata[0];
      w[1] = p1_we[0];  af[1] = p1_addr[0];  d[1] = p1_wdata[0];
      t_iss  = '{-1, -1};
      t_done = '{-1, -1};
      last   = 0;
      if (r0 && r1 && d1 == 0) first = (model_last == 1) ? 0 : 1;
      else                     first = r0 ? 0 : 1;
      for (int s = 0; s < 2; s++) begin
         int p;
         p = (s == 0) ? first : 1 - first;
         if ((p == 0 && r0) || (p == 1 && r1)) begin
            t_iss[p]  = (s == 0) ? 1 : L0 + 4;
            t_done[p] = t_iss[p] + L0 + 1;
            if (w[p]) model_mem[af[p][3:0]] = d[p];
            else      model_rd[p] = model_mem[af[p][3:0]];
            model_last = p;
            last = t_done[p];
         end
      end
      p0_req[0] = r0;
      p1_req[0] = r1 && (d1 == 0);
      for (int k = 0; k <= last + 1; k++) begin
         @(negedge clk);
         check1("mem_en", mem_en[0], k == t_iss[0] || k == t_iss[1]);
         for (int p = 0; p < 2; p++) begin
            if (k == t_iss[p]) begin
               check1("mem_we", mem_we[0], w[p]);
               check("mem_addr", DW'(mem_addr[0]), DW'(af[p]));
               check("mem_wdata", mem_wdata[0], d[p]);
            end
         end
         check1("p0_done", p0_done[0], k == t_done[0]);
         check1("p1_done", p1_done[0], k == t_done[1]);
         check1("stall_m", stall_m[0], t_done[0] >= 0 && k < t_done[0]);
         if (k == t_done[0]) check("p0_rdata", p0_rdata[0], model_rd[0]);
         if (k == t_done[1]) check("p1_rdata", p1_rdata[0], model_rd[1]);
         @(posedge clk);
         #1;
         if (k == t_done[0]) p0_req[0] = 1'b0;
         if (k == t_done[1]) p1_req[0] = 1'b0;
         if (r1 && d1 > 0 && k + 1 == d1) p1_req[0] = 1'b1;
      end
   endtask

   task automatic lat_test(input int g, input int lat);
      int k;
      p0_we[g]   = 1'b0;
      p0_addr[g] = 32'h0000_0043;
      p0_req[g]  = 1'b1;
      k = 0;
      while (k < 40) begin
         @(negedge clk);
         if (p0_done[g]) break;
         @(posedge clk);
         #1;
         k++;
      end
      check("latency", DW'(k), DW'(lat + 2));
      check("lat_rdata", p0_rdata[g], init_word(3));
      @(posedge clk);
      #1;
      p0_req[g] = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      p0_req = '0; p0_we = '0; p0_addr = '0; p0_wdata = '0;
      p1_req = '0; p1_we = '0; p1_addr = '0; p1_wdata = '0;
      for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
      model_rd   = '{'0, '0};
      model_last = 1;

      repeat (3) @(negedge clk);
      check1("rst_mem_en", mem_en[0], 1'b0);
      check1("rst_mem_we", mem_we[0], 1'b0);
      check("rst_mem_addr", DW'(mem_addr[0]), '0);
      check("rst_p0_rdata", p0_rdata[0], '0);
      check1("rst_p1_done", p1_done[0], 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Tie straight after reset goes to port 0, the repeated tie to port 1.
      p0_we[0] = 1'b0; p0_addr[0] = 32'h0000_0041;
      p1_we[0] = 1'b0; p1_addr[0] = 32'h0000_0042;
      step(1'b1, 1'b1, 0);
      step(1'b1, 1'b1, 0);

      // Loader writes, then a pipeline read of what was written.
      p1_we[0] = 1'b1; p1_addr[0] = 32'h0000_0080; p1_wdata[0] = {64{4'h5}};
      step(1'b0, 1'b1, 0);
      p1_addr[0] = 32'h0000_0040; p1_wdata[0] = {64{4'hA}};
      step(1'b0, 1'b1, 0);
      p0_we[0] = 1'b0; p0_addr[0] = 32'h0000_0040;
      step(1'b1, 1'b0, 0);

      // Loader arrives while the pipeline access is in WAIT.
      p1_we[0] = 1'b0; p1_addr[0] = 32'h0000_0083;
      step(1'b1, 1'b1, 2);

      for (int n = 0; n < 30; n++) begin
         int kind;
         kind = $urandom_range(0, 2);
         rand_payload();
         step(kind != 1, kind != 0, (kind == 2) ? $urandom_range(0, L0 + 3) : 0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      // Reset in the middle of a read: everything clears, no done, held request restarts cleanly.
      p0_we[0] = 1'b0; p0_addr[0] = 32'h0000_0045; p0_wdata[0] = {8{32'h1234_5678}};
      p0_req[0] = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      #1;
      check1("wrst_mem_en", mem_en[0], 1'b0);
      check1("wrst_mem_we", mem_we[0], 1'b0);
      check("wrst_mem_addr", DW'(mem_addr[0]), '0);
      check("wrst_mem_wdata", mem_wdata[0], '0);
      check("wrst_p0_rdata", p0_rdata[0], '0);
      check("wrst_p1_rdata", p1_rdata[0], '0);
      check1("wrst_stall_m", stall_m[0], 1'b1);
      repeat (3) begin
         @(negedge clk);
         check1("wrst_p0_done", p0_done[0], 1'b0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_rd   = '{'0, '0};
      model_last = 1;
      step(1'b1, 1'b0, 0);

      lat_test(1, 1);
      lat_test(2, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single 256-bit vector data memory between the pipeline Memory stage (port 0) and the FIR sample/coefficient loader (port 1). Round-robin arbitration, one outstanding access at a time, a fixed-latency memory sequencer, and a stall signal back to the hazard logic while the pipeline's access is pending. Sits between Memory_Cycle/loader and the data-memory macro.

## Interface
- DATA_W, 256: data width of all data buses
- ADDR_W, 32: address width
- MEM_LAT, 2: memory read latency in cycles, legal range 1..15
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- p0_req  in  1  pipeline access request; held with payload until p0_done
- p0_we  in  1  pipeline write (1) / read (0)
- p0_addr  in  ADDR_W  pipeline address
- p0_wdata  in  DATA_W  pipeline write data
- p0_rdata  out  DATA_W  pipeline read data, registered
- p0_done  out  1  one-cycle completion pulse
- stall_m  out  1  p0_req & ~p0_done, combinational, to hazard unit
- p1_req, p1_we, p1_addr, p1_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as port 0
- p1_rdata  out  DATA_W  loader read data, registered
- p1_done  out  1  one-cycle completion pulse
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write enable, valid with mem_en
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  valid exactly MEM_LAT cycles after the mem_en cycle

## Operation
- FSM: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req, pick the winner, latch grant (gnt: 0/1), latch winner's we/addr/wdata into mem_* registers, go to ISSUE; else stay.
- Arbitration: one requester → it wins. Both → the port not in last_grant wins; last_grant updated on every grant. Reset value of last_grant = 1, so port 0 wins the first tie.
- ISSUE: mem_en=1 for this cycle only; counter loaded with MEM_LAT; go to WAIT.
- WAIT: counter decrements each cycle; in the cycle counter reaches 1 (MEM_LAT cycles after ISSUE), sample mem_rdata into granted port's rdata register if read; go to DONE.
- DONE: granted port's done=1; go to IDLE. Requests are not sampled in DONE.
- Writes follow the same sequence; rdata registers untouched on write.
- pX_rdata hold their value until the next read completion on that port.
- Requester contract: payload stable from req rise until done; drop req (or present a new request) the cycle after done. Payload changes mid-access are ignored (already latched).
- mem_addr/mem_we/mem_wdata hold the last issued value outside ISSUE.

## Timing
- Request present in IDLE cycle t: ISSUE at t+1 (mem_en), rdata captured at edge ending t+1+MEM_LAT, done at t+2+MEM_LAT. Request-to-done latency MEM_LAT+2.
- Back-to-back from the same port: next IDLE sample at t+3+MEM_LAT; throughput one access per MEM_LAT+3 cycles.
- Loser of a tie is granted in the IDLE following the winner's DONE. Worst-case wait is one full access. No starvation.
- stall_m is high from the cycle p0_req rises through the cycle before p0_done, and low in the p0_done cycle.
- Reset (rst=0, any state including WAIT): state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, p0_rdata=p1_rdata=0, p0_done=p1_done=0, counter=0, last_grant=1. An in-flight access is abandoned without done. The memory response arriving after reset is ignored.
- Requests asserted during reset are arbitrated in the first IDLE cycle after rst rises.

## Test plan
- MEM_LAT=2, p0 read addr 0x40 at t=0, memory returns 0xAA..AA: mem_en at t=1 with mem_addr=0x40, p0_done at t=4, p0_rdata=0xAA..AA, stall_m high t=0..3, low at t=4.
- p0 and p1 requests rise in the same cycle after reset: p0 granted first (done at t=4), then p1 ISSUE at t=6, done at t=9. Repeat the tie: p1 now wins first.
- p1 write addr 0x80 data 0x55..55 while p0 idle: mem_en=1, mem_we=1, mem_wdata=0x55..55 at t=1, p1_done at t=4, p1_rdata unchanged.
- p1 request while p0 access in WAIT: p1 waits, its ISSUE occurs the cycle after p0 IDLE re-entry (t=6), no overlap of mem_en.
- Reset asserted during WAIT: all outputs zero immediately, no done pulse. The held request after reset release completes normally in MEM_LAT+2 cycles.
- MEM_LAT=1 and MEM_LAT=15 builds: request-to-done latency 3 and 17 cycles respectively.
